iic_txn_arbiter: RTL and testbench
==================================

Name: iic_txn_arbiter

Overview:
- Shares one iic_controller master between NUM_REQ independent requesters.
- Round-robin arbitration selects one write transaction (7-bit slave address + 8-bit data) at a time and sequences the master through start, completion wait, NACK retry with backoff, and a timeout watchdog.
- Returns a per-requester completion pulse with status.
- Sits between the system-side register/command logic and the single iic_controller instance driving SDA/SCL.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 7, slave address width.
- DATA_W, 8, data byte width.
- MAX_RETRY, 2, extra attempts after a NACK (0 = no retry).
- BACKOFF_CYCLES, 64, clk cycles idle between a NACK and the retry.
- TIMEOUT_CYCLES, 4096, clk cycles allowed in WAIT before abort.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request; held until its req_ready pulse.
- req_addr  in  NUM_REQ*ADDR_W  packed slave addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  packed data bytes, same packing.
- req_ready  out  NUM_REQ  one-hot, 1-cycle accept pulse.
- resp_valid  out  NUM_REQ  one-hot, 1-cycle completion pulse.
- resp_status  out  2  valid with resp_valid: 00 OK, 01 NACK (retries exhausted), 10 TIMEOUT.
- mst_start  out  1  1-cycle start pulse to the master.
- mst_addr  out  ADDR_W  slave address to the master.
- mst_data  out  DATA_W  data byte to the master.
- mst_abort  out  1  1-cycle pulse; master returns to idle and releases the bus.
- mst_busy  in  1  master is mid-transaction.
- mst_done  in  1  1-cycle pulse; transaction finished.
- mst_nack  in  1  valid with mst_done; slave did not ACK.

Behaviour:
- Reset:
  - state=IDLE, rr_ptr=0, retry_cnt=0, timer=0.
  - All outputs 0: req_ready, resp_valid, resp_status, mst_start, mst_abort, mst_addr, mst_data.
- rst asserted in any state, including mid-WAIT:
  - Returns to IDLE next cycle with no resp_valid for the in-flight requester.
  - The master is reset by the same rst.
- States: IDLE, GRANT, ISSUE, WAIT, BACKOFF, RESP.
- IDLE:
  - If any req_valid, select the first set bit scanning from rr_ptr upward with wrap and register the grant index g.
  - Go to GRANT.
- GRANT:
  - req_ready[g]=1 for exactly this cycle.
  - Latch req_addr[g] and req_data[g] into mst_addr and mst_data; these hold constant until RESP exits.
  - retry_cnt=0. Go to ISSUE.
- ISSUE:
  - If mst_busy=1, stall in ISSUE with mst_start=0.
  - Otherwise mst_start=1 for one cycle, timer=0, go to WAIT.
- WAIT (timer increments each cycle):
  - mst_done & !mst_nack: status=OK, go to RESP.
  - mst_done & mst_nack & retry_cnt<MAX_RETRY: retry_cnt++, timer=0, go to BACKOFF.
  - mst_done & mst_nack & retry_cnt==MAX_RETRY: status=NACK, go to RESP.
  - timer==TIMEOUT_CYCLES-1 without mst_done: mst_abort=1 for one cycle, status=TIMEOUT, go to RESP.
  - mst_done in the same cycle as timeout expiry: mst_done wins; no abort.
- BACKOFF:
  - Count to BACKOFF_CYCLES-1, then go to ISSUE.
- RESP:
  - resp_valid[g]=1 and resp_status driven, for one cycle.
  - rr_ptr=(g+1) mod NUM_REQ. Go to IDLE.
- Latency:
  - Sampled req_valid in IDLE -> req_ready the next cycle -> mst_start the cycle after that (2 cycles) when the master is idle.
  - mst_done -> resp_valid 1 cycle later.
  - Back-to-back requests: minimum 1 IDLE cycle between RESP and the next GRANT.
- Arbitration:
  - Round-robin, strictly fair; a requester that just completed has lowest priority next round.
  - req_valid deasserting after grant has no effect.
  - req_valid deasserting before grant simply drops out of arbitration.
- Widths:
  - timer is $clog2(TIMEOUT_CYCLES) bits; it cannot wrap because expiry forces an exit.
  - retry_cnt is $clog2(MAX_RETRY+1) bits, minimum 1.
- mst_start and mst_abort are never asserted in the same cycle.

Decomposition:
- Package iic_pkg:
  - Status codes: IIC_ST_OK=2'b00, IIC_ST_NACK=2'b01, IIC_ST_TIMEOUT=2'b10.
  - Arbiter state encoding constants.
  - Shared ADDR_W/DATA_W defaults.
- Sub-module iic_rr_arbiter:
  - Pure round-robin picker: req vector + ptr -> one-hot grant + index + any_req.
  - Combinational, parameterised by NUM_REQ; unit-testable alone.

Test Plan:
- Single requester: req_valid=4'b0001, addr=7'h42, data=8'hAA; master ACKs -> req_ready[0] 1 cycle after valid, mst_start 2 cycles after, mst_addr=7'h42, mst_data=8'hAA, resp_valid[0] with status 00.
- Fairness: all four valid continuously, every transaction ACKed -> grant order 0,1,2,3,0,1; no requester granted twice before the others.
- NACK retry: MAX_RETRY=2, master NACKs twice then ACKs -> 3 mst_start pulses each ≥BACKOFF_CYCLES apart, status 00. With 3 NACKs -> exactly 3 starts, status 01.
- Timeout: TIMEOUT_CYCLES=16, master never pulses mst_done -> mst_abort at cycle 16 after mst_start, resp_status 10, next requester served.
- Boundary: mst_done arrives on the exact expiry cycle -> status 00, no mst_abort. mst_busy held high in ISSUE for 10 cycles -> mst_start delayed 10 cycles.
- Reset mid-WAIT: assert rst for 1 cycle during WAIT -> all outputs 0 the next cycle, no resp_valid, rr_ptr=0, the next request is served normally.

Source files
------------

// File: rtl/iic_pkg.sv
// Shared constants for the I2C transaction arbiter.
// Status codes, FSM state encodings and default field widths.
package iic_pkg;

    localparam int unsigned IIC_ADDR_W = 7;
    localparam int unsigned IIC_DATA_W = 8;

    typedef logic [1:0] iic_status_t;

    localparam iic_status_t IIC_ST_OK      = 2'b00;
    localparam iic_status_t IIC_ST_NACK    = 2'b01;
    localparam iic_status_t IIC_ST_TIMEOUT = 2'b10;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_GRANT   = 3'd1;
    localparam logic [2:0] ST_ISSUE   = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_BACKOFF = 3'd4;
    localparam logic [2:0] ST_RESP    = 3'd5;

    function automatic int unsigned iic_max(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/iic_rr_arbiter.sv
// Combinational round-robin picker.
// Scans from ptr upward with wrap; reports one-hot grant and its index.
module iic_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      idx_o,
    output logic               any_o
);

    // First set request at or after ptr, wrapping to zero.
    always_comb begin
        int unsigned j;
        logic [IW-1:0] jw;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        jw    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            jw = IW'(j);
            if (!any_o && req_i[jw]) begin
                gnt_o[jw] = 1'b1;
                idx_o     = jw;
                any_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iic_txn_arbiter.sv
// Shares one I2C master between NUM_REQ write requesters.
// Handles grant, start, NACK retry with backoff and a WAIT watchdog.
module iic_txn_arbiter
    import iic_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_W         = IIC_ADDR_W,
    parameter int unsigned DATA_W         = IIC_DATA_W,
    parameter int unsigned MAX_RETRY      = 2,
    parameter int unsigned BACKOFF_CYCLES = 64,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [1:0]                resp_status,
    output logic                      mst_start,
    output logic [ADDR_W-1:0]         mst_addr,
    output logic [DATA_W-1:0]         mst_data,
    output logic                      mst_abort,
    input  logic                      mst_busy,
    input  logic                      mst_done,
    input  logic                      mst_nack
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned TW =
        $clog2(iic_max(iic_max(TIMEOUT_CYCLES, BACKOFF_CYCLES), 2));
    localparam int unsigned RW =
        (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] BO_LAST   = TW'(BACKOFF_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

    logic [2:0]         state_q, state_d;
    logic [IW-1:0]      g_q, g_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [RW-1:0]      retry_q, retry_d;
    logic [TW-1:0]      timer_q, timer_d;
    iic_status_t        status_q, status_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;

    iic_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Transaction sequencing: grant, issue, wait/retry, respond.
    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        retry_d  = retry_q;
        timer_d  = timer_q;
        status_d = status_q;
        addr_d   = addr_q;
        data_d   = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    g_d     = arb_idx;
                    gnt_d   = arb_gnt;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                addr_d  = req_addr[g_q*ADDR_W +: ADDR_W];
                data_d  = req_data[g_q*DATA_W +: DATA_W];
                retry_d = '0;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!mst_busy) begin
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mst_done) begin
                    if (!mst_nack) begin
                        status_d = IIC_ST_OK;
                        state_d  = ST_RESP;
                    end else if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        timer_d = '0;
                        state_d = ST_BACKOFF;
                    end else begin
                        status_d = IIC_ST_NACK;
                        state_d  = ST_RESP;
                    end
                end else if (timer_q == TMO_LAST) begin
                    status_d = IIC_ST_TIMEOUT;
                    state_d  = ST_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_BACKOFF: begin
                if (timer_q == BO_LAST) begin
                    state_d = ST_ISSUE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RESP: begin
                rr_ptr_d = (g_q == LAST_IDX) ? '0 : g_q + 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            g_q      <= '0;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            retry_q  <= '0;
            timer_q  <= '0;
            status_q <= IIC_ST_OK;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            retry_q  <= retry_d;
            timer_q  <= timer_d;
            status_q <= status_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign req_ready   = (state_q == ST_GRANT) ? gnt_q : '0;
    assign resp_valid  = (state_q == ST_RESP) ? gnt_q : '0;
    assign resp_status = (state_q == ST_RESP) ? status_q : IIC_ST_OK;
    assign mst_start   = (state_q == ST_ISSUE) && !mst_busy;
    // A done on the expiry cycle takes priority over the abort.
    assign mst_abort   = (state_q == ST_WAIT) && !mst_done &&
                         (timer_q == TMO_LAST);
    assign mst_addr    = addr_q;
    assign mst_data    = data_q;

endmodule

// File: tb/tb_iic_txn_arbiter.sv
// Scoreboard bench for iic_txn_arbiter.
// Random and directed episodes against a transaction-level model.
module tb_iic_txn_arbiter;

    import iic_pkg::*;

    localparam int NREQ = 4;
    localparam int AW   = 7;
    localparam int DW   = 8;
    localparam int MR   = 2;
    localparam int NATT = MR + 1;
    localparam int BO   = 20;
    localparam int TO   = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      resp_valid;
    logic [1:0]           resp_status;
    logic                 mst_start;
    logic [AW-1:0]        mst_addr;
    logic [DW-1:0]        mst_data;
    logic                 mst_abort;
    logic                 mst_busy;
    logic                 mst_done;
    logic                 mst_nack;

    iic_txn_arbiter #(
        .NUM_REQ        (NREQ),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .MAX_RETRY      (MR),
        .BACKOFF_CYCLES (BO),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_status (resp_status),
        .mst_start   (mst_start),
        .mst_addr    (mst_addr),
        .mst_data    (mst_data),
        .mst_abort   (mst_abort),
        .mst_busy    (mst_busy),
        .mst_done    (mst_done),
        .mst_nack    (mst_nack)
    );

    typedef struct {
        int          idx;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]  status;
        int          starts;
        int          aborts;
        int          stall;
    } exp_t;

    exp_t expq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int resp_seen = 0;
    int ptr   = 0;
    bit mon_en = 1'b0;
    bit stop_run = 1'b0;

    int            pdel  [NREQ][NATT];
    bit            pnack [NREQ][NATT];
    int            pstall[NREQ];
    logic [AW-1:0] taddr [NREQ];
    logic [DW-1:0] tdata [NREQ];

    int m_cur = 0;
    int m_att = 0;
    int m_busy_left = 0;
    int m_cnt = 0;
    bit m_pend = 1'b0;
    bit m_nack = 1'b0;

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act,
                         input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int oh2i(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Outcome of a whole transaction from its list of attempt results.
    task automatic predict(input int i, output logic [1:0] st,
                           output int starts, output int aborts);
        st = IIC_ST_NACK;
        starts = NATT;
        aborts = 0;
        for (int k = 0; k < NATT; k++) begin
            starts = k + 1;
            if (pdel[i][k] == 0) begin
                st = IIC_ST_TIMEOUT;
                aborts = 1;
                return;
            end
            if (!pnack[i][k]) begin
                st = IIC_ST_OK;
                return;
            end
        end
    endtask

    task automatic set_plan(input int i, input int d0, input bit n0,
                            input int d1, input bit n1, input int d2,
                            input bit n2, input int st);
        pdel[i][0] = d0; pnack[i][0] = n0;
        pdel[i][1] = d1; pnack[i][1] = n1;
        pdel[i][2] = d2; pnack[i][2] = n2;
        pstall[i] = st;
        taddr[i] = AW'($urandom);
        tdata[i] = DW'($urandom);
    endtask

    task automatic rand_plan(input int i);
        int r;
        pstall[i] = $urandom_range(0, 3);
        for (int k = 0; k < NATT; k++) begin
            r = $urandom_range(0, 99);
            pdel[i][k]  = (r < 85) ? $urandom_range(1, TO) : 0;
            pnack[i][k] = (r >= 55 && r < 85);
        end
        taddr[i] = AW'($urandom);
        tdata[i] = DW'($urandom);
    endtask

    task automatic drive_fields();
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW] = taddr[i];
            req_data[i*DW +: DW] = tdata[i];
        end
    endtask

    task automatic run_episode(input logic [NREQ-1:0] set);
        logic [NREQ-1:0] left;
        logic [NREQ-1:0] rdy;
        int n;
        int g;
        int waited;
        exp_t e;
        if (stop_run) return;
        left = set;
        n = 0;
        while (left != 0) begin
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && left[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
            end
            left[g] = 1'b0;
            ptr = (g + 1) % NREQ;
            e.idx = g;
            e.addr = taddr[g];
            e.data = tdata[g];
            e.stall = pstall[g];
            predict(g, e.status, e.starts, e.aborts);
            expq.push_back(e);
            n++;
        end
        resp_seen = 0;
        @(posedge clk); #1;
        drive_fields();
        req_valid = set;
        waited = 0;
        while (resp_seen < n && waited < 300 * n) begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk); #1;
            req_valid = req_valid & ~rdy;
            waited++;
        end
        check("episode_done", resp_seen, n);
        if (resp_seen < n) begin
            req_valid = '0;
            expq.delete();
            stop_run = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Bench-side master: busy stall, then done/nack per attempt plan.
    initial begin : master
        mst_busy = 1'b0;
        mst_done = 1'b0;
        mst_nack = 1'b0;
        forever begin
            @(negedge clk);
            if (req_ready != 0 && oh2i(req_ready) >= 0) begin
                m_cur = oh2i(req_ready);
                m_att = 0;
                m_busy_left = pstall[m_cur];
            end
            if (mst_start) begin
                if (m_att < NATT && pdel[m_cur][m_att] > 0) begin
                    m_pend = 1'b1;
                    m_cnt  = pdel[m_cur][m_att];
                    m_nack = pnack[m_cur][m_att];
                end
                m_att++;
            end
            if (mst_abort) m_pend = 1'b0;
            @(posedge clk); #1;
            mst_done = 1'b0;
            mst_nack = 1'b0;
            mst_busy = (m_busy_left > 0);
            if (m_busy_left > 0) m_busy_left--;
            if (m_pend) begin
                if (m_cnt == 1) begin
                    mst_done = 1'b1;
                    mst_nack = m_nack;
                    m_pend = 1'b0;
                end else begin
                    m_cnt--;
                end
            end
        end
    end

    // Monitor: timing checks on the fly, scoreboard pop on resp_valid.
    initial begin : monitor
        int g_cyc;
        int last_start;
        int last_done;
        int last_evt;
        int last_resp;
        int starts;
        int aborts;
        exp_t e;
        g_cyc = 0; last_start = 0; last_done = 0; last_evt = 0;
        last_resp = -10; starts = 0; aborts = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                starts = 0;
                aborts = 0;
                last_resp = -10;
            end else begin
                if (mst_start && mst_abort) check("start_abort_overlap", 1, 0);
                if (req_ready != 0) begin
                    check("ready_onehot", $countones(req_ready), 1);
                    check("idle_gap", (cyc - last_resp) >= 2, 1);
                    if (expq.size() == 0) check("unexpected_grant", oh2i(req_ready), -1);
                    else check("grant_idx", oh2i(req_ready), expq[0].idx);
                    g_cyc = cyc;
                    starts = 0;
                    aborts = 0;
                end
                if (mst_start) begin
                    if (expq.size() == 0) begin
                        check("unexpected_start", 1, 0);
                    end else if (starts == 0) begin
                        check("start_latency", cyc - g_cyc, 1 + expq[0].stall);
                        check("start_addr", mst_addr, expq[0].addr);
                        check("start_data", mst_data, expq[0].data);
                    end else begin
                        check("backoff_gap", cyc - last_done, BO + 1);
                    end
                    starts++;
                    last_start = cyc;
                end
                if (mst_done) begin
                    last_done = cyc;
                    last_evt = cyc;
                end
                if (mst_abort) begin
                    check("abort_time", cyc - last_start, TO);
                    aborts++;
                    last_evt = cyc;
                end
                if (resp_valid != 0) begin
                    resp_seen++;
                    last_resp = cyc;
                    if (expq.size() == 0) begin
                        check("unexpected_resp", oh2i(resp_valid), -1);
                    end else begin
                        e = expq.pop_front();
                        check("resp_onehot", $countones(resp_valid), 1);
                        check("resp_idx", oh2i(resp_valid), e.idx);
                        check("resp_status", resp_status, e.status);
                        check("resp_latency", cyc - last_evt, 1);
                        check("start_count", starts, e.starts);
                        check("abort_count", aborts, e.aborts);
                        check("hold_addr", mst_addr, e.addr);
                        check("hold_data", mst_data, e.data);
                    end
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_status"}, resp_status, 0);
        check({tag, "_mst_start"}, mst_start, 0);
        check({tag, "_mst_abort"}, mst_abort, 0);
        check({tag, "_mst_addr"}, mst_addr, 0);
        check({tag, "_mst_data"}, mst_data, 0);
    endtask

    initial begin : stim
        bit seen;
        bit resp_any;
        int waited;
        req_valid = '0;
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < NREQ; i++) set_plan(i, 1, 0, 1, 0, 1, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        set_plan(0, 2, 0, 1, 0, 1, 0, 0);
        taddr[0] = 7'h42;
        tdata[0] = 8'hAA;
        run_episode(4'b0001);

        for (int i = 0; i < NREQ; i++) set_plan(i, $urandom_range(1, 4), 0, 1, 0, 1, 0, 0);
        run_episode(4'b1111);
        for (int i = 0; i < NREQ; i++) set_plan(i, $urandom_range(1, 4), 0, 1, 0, 1, 0, 0);
        run_episode(4'b1111);

        set_plan(2, 3, 1, 5, 1, 2, 0, 0);
        run_episode(4'b0100);
        set_plan(3, 3, 1, 4, 1, 6, 1, 0);
        run_episode(4'b1000);
        set_plan(0, 0, 0, 0, 0, 0, 0, 0);
        set_plan(1, 3, 0, 1, 0, 1, 0, 0);
        run_episode(4'b0011);
        set_plan(1, TO, 0, 1, 0, 1, 0, 0);
        run_episode(4'b0010);
        set_plan(2, 4, 0, 1, 0, 1, 0, 10);
        run_episode(4'b0100);

        for (int ep = 0; ep < 30; ep++) begin
            for (int i = 0; i < NREQ; i++) rand_plan(i);
            run_episode(NREQ'($urandom_range(1, 15)));
        end

        set_plan(1, 2, 0, 1, 0, 1, 0, 0);
        run_episode(4'b0010);

        if (!stop_run) begin
            mon_en = 1'b0;
            set_plan(2, 0, 0, 0, 0, 0, 0, 0);
            @(posedge clk); #1;
            drive_fields();
            req_valid = 4'b0100;
            seen = 1'b0;
            waited = 0;
            while (!seen && waited < 50) begin
                @(negedge clk);
                if (mst_start) seen = 1'b1;
                waited++;
            end
            check("rst_test_start", seen, 1);
            repeat (5) @(posedge clk);
            #1;
            rst = 1'b1;
            req_valid = '0;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            check_outputs_zero("post_rst");
            resp_any = 1'b0;
            repeat (30) begin
                @(negedge clk);
                if (resp_valid != 0) resp_any = 1'b1;
            end
            check("post_rst_no_resp", resp_any, 0);
            ptr = 0;
            m_pend = 1'b0;
            m_busy_left = 0;
            mon_en = 1'b1;
            set_plan(1, 3, 0, 1, 0, 1, 0, 0);
            set_plan(3, 5, 0, 1, 0, 1, 0, 1);
            run_episode(4'b1010);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
